// File: rtl/tug_referee.sv
`default_nettype none
// ============================================================================
// Module      : tug_referee
// Description : Game-sequencing controller for the 7-LED tug-of-war board.
//               Arbitrates left/right push pulses into at most one rope move
//               per slow tick, detects the win, holds a cheer phase for a
//               fixed number of ticks, then re-serves the rope at centre
//               behind a short push lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module tug_referee #(
    parameter int CHEER_TICKS = 13,
    parameter int SERVE_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slowen,
    input  logic       pl,
    input  logic       pr,
    output logic [6:0] score,
    output logic       wingame,
    output logic       right_win,
    output logic       ready,
    output logic [7:0] moves
);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_CHEER = 2'd2
    } state_t;

    // Terminal counts: the tick that reaches N is the (N-1) -> N increment.
    localparam logic [3:0] c_SERVE_LAST = 4'(SERVE_TICKS - 1);
    localparam logic [3:0] c_CHEER_LAST = 4'(CHEER_TICKS - 1);
    localparam logic [2:0] c_POS_CENTRE = 3'd3;
    localparam logic [2:0] c_POS_LEFT   = 3'd6;
    localparam logic [2:0] c_POS_RIGHT  = 3'd0;

    state_t     r_state;
    logic [2:0] r_pos;
    logic       r_pend_l;
    logic       r_pend_r;
    logic [3:0] r_cnt;

    logic       w_move_l;
    logic       w_move_r;
    logic [2:0] w_new_pos;

    // Resolve the pending pushes into the candidate rope position for this tick.
    always_comb begin
        w_move_l  = r_pend_l & ~r_pend_r;
        w_move_r  = r_pend_r & ~r_pend_l;
        w_new_pos = r_pos;
        if (w_move_l) begin
            w_new_pos = r_pos + 3'd1;
        end else if (w_move_r) begin
            w_new_pos = r_pos - 3'd1;
        end
    end

    // Game FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_SERVE;
            r_pos     <= c_POS_CENTRE;
            score     <= 7'b0001000;
            r_pend_l  <= 1'b0;
            r_pend_r  <= 1'b0;
            r_cnt     <= 4'd0;
            wingame   <= 1'b0;
            right_win <= 1'b0;
            ready     <= 1'b0;
            moves     <= 8'd0;
        end else begin
            case (r_state)
                S_SERVE: begin
                    r_pend_l <= 1'b0;
                    r_pend_r <= 1'b0;
                    if (slowen) begin
                        if (r_cnt == c_SERVE_LAST) begin
                            r_state <= S_PLAY;
                            r_cnt   <= 4'd0;
                            ready   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end

                S_PLAY: begin
                    if (slowen) begin
                        r_pos <= w_new_pos;
                        score <= 7'b0000001 << w_new_pos;
                        if ((w_move_l || w_move_r) && (moves != 8'hFF)) begin
                            moves <= moves + 8'd1;
                        end
                        if (w_new_pos == c_POS_LEFT || w_new_pos == c_POS_RIGHT) begin
                            // Pushes landing on the winning edge are dropped.
                            r_state   <= S_CHEER;
                            r_cnt     <= 4'd0;
                            r_pend_l  <= 1'b0;
                            r_pend_r  <= 1'b0;
                            wingame   <= 1'b1;
                            right_win <= (w_new_pos == c_POS_RIGHT);
                            ready     <= 1'b0;
                        end else begin
                            // Same-cycle pushes start the next tick period fresh.
                            r_pend_l <= pl;
                            r_pend_r <= pr;
                        end
                    end else begin
                        r_pend_l <= r_pend_l | pl;
                        r_pend_r <= r_pend_r | pr;
                    end
                end

                S_CHEER: begin
                    r_pend_l <= 1'b0;
                    r_pend_r <= 1'b0;
                    if (slowen) begin
                        if (r_cnt == c_CHEER_LAST) begin
                            r_state   <= S_SERVE;
                            r_pos     <= c_POS_CENTRE;
                            score     <= 7'b0001000;
                            r_cnt     <= 4'd0;
                            moves     <= 8'd0;
                            wingame   <= 1'b0;
                            right_win <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    r_state   <= S_SERVE;
                    r_pos     <= c_POS_CENTRE;
                    score     <= 7'b0001000;
                    r_pend_l  <= 1'b0;
                    r_pend_r  <= 1'b0;
                    r_cnt     <= 4'd0;
                    wingame   <= 1'b0;
                    right_win <= 1'b0;
                    ready     <= 1'b0;
                    moves     <= 8'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tug_referee.sv
`default_nettype none
// ============================================================================
// Module      : tb_tug_referee
// Description : Directed self-checking bench for tug_referee.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tug_referee;

    logic       clk;
    logic       rst;
    logic       slowen;
    logic       pl;
    logic       pr;
    logic [6:0] score;
    logic       wingame;
    logic       right_win;
    logic       ready;
    logic [7:0] moves;

    int checks;
    int errors;

    tug_referee #(
        .CHEER_TICKS(13),
        .SERVE_TICKS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slowen    (slowen),
        .pl        (pl),
        .pr        (pr),
        .score     (score),
        .wingame   (wingame),
        .right_win (right_win),
        .ready     (ready),
        .moves     (moves)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs driven at the falling edge, outputs sampled 1 after the rise.
    task automatic cyc(input logic s, input logic l, input logic r);
        @(negedge clk);
        slowen = s;
        pl     = l;
        pr     = r;
        @(posedge clk);
        #1;
        slowen = 1'b0;
        pl     = 1'b0;
        pr     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] e_score, input logic e_win,
                           input logic e_rwin, input logic e_ready, input logic [7:0] e_moves);
        chk({tag, ".score"},     {1'b0, score},     {1'b0, e_score});
        chk({tag, ".wingame"},   {7'd0, wingame},   {7'd0, e_win});
        chk({tag, ".right_win"}, {7'd0, right_win}, {7'd0, e_rwin});
        chk({tag, ".ready"},     {7'd0, ready},     {7'd0, e_ready});
        chk({tag, ".moves"},     moves,             e_moves);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        slowen = 1'b0;
        pl     = 1'b0;
        pr     = 1'b0;

        // Reset held for two clocks.
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk_all("reset", 7'b0001000, 0, 0, 0, 8'd0);
        rst = 1'b1;

        // Serve: pushes ignored, two ticks to PLAY.
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        chk_all("serve_push", 7'b0001000, 0, 0, 0, 8'd0);
        cyc(1, 0, 0);
        chk_all("serve_tick1", 7'b0001000, 0, 0, 0, 8'd0);
        cyc(1, 0, 0);
        chk_all("serve_tick2", 7'b0001000, 0, 0, 1, 8'd0);
        cyc(1, 0, 0);
        chk_all("play_idle_tick", 7'b0001000, 0, 0, 1, 8'd0);

        // Single moves and duplicate push.
        cyc(0, 1, 0);
        chk_all("pl_pending", 7'b0001000, 0, 0, 1, 8'd0);
        cyc(1, 0, 0);
        chk_all("move_left", 7'b0010000, 0, 0, 1, 8'd1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk_all("move_right_dup", 7'b0001000, 0, 0, 1, 8'd2);

        // Cancel, then push coincident with the tick.
        cyc(0, 1, 1);
        cyc(1, 0, 0);
        chk_all("cancel", 7'b0001000, 0, 0, 1, 8'd2);
        cyc(1, 1, 0);
        chk_all("same_cycle_push", 7'b0001000, 0, 0, 1, 8'd2);
        cyc(1, 0, 0);
        chk_all("same_cycle_next", 7'b0010000, 0, 0, 1, 8'd3);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk_all("back_centre", 7'b0001000, 0, 0, 1, 8'd4);

        // Right win.
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk_all("rwin_step1", 7'b0000100, 0, 0, 1, 8'd5);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk_all("rwin_step2", 7'b0000010, 0, 0, 1, 8'd6);
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk_all("rwin", 7'b0000001, 1, 1, 0, 8'd7);

        // Cheer: pushes ignored, 13 ticks.
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        chk_all("cheer_push", 7'b0000001, 1, 1, 0, 8'd7);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0);
        chk_all("cheer_tick12", 7'b0000001, 1, 1, 0, 8'd7);
        cyc(1, 0, 0);
        chk_all("cheer_done", 7'b0001000, 0, 0, 0, 8'd0);

        // Serve again, then left win.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk_all("serve2", 7'b0001000, 0, 0, 1, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            cyc(1, 0, 0);
        end
        chk_all("lwin", 7'b1000000, 1, 0, 0, 8'd3);

        // Reset in the middle of cheer.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        rst = 1'b0;
        cyc(1, 1, 0);
        chk_all("reset_mid_cheer", 7'b0001000, 0, 0, 0, 8'd0);
        rst = 1'b1;

        // Saturation: 300 alternating non-cancelled moves around centre.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk_all("serve3", 7'b0001000, 0, 0, 1, 8'd0);
        for (int i = 0; i < 300; i++) begin
            cyc(0, (i % 2) == 0, (i % 2) == 1);
            cyc(1, 0, 0);
            if (i == 253) chk("moves_254", moves, 8'd254);
            if (i == 254) chk("moves_255", moves, 8'd255);
        end
        chk_all("saturated", 7'b0001000, 0, 0, 1, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
